// File: rtl/clint_timer.sv
// clint_timer: machine-mode local interrupt source (CLINT style).
//
// Holds the 64-bit mtime counter, the mtimecmp compare register and the
// msip software-interrupt bit, and synchronises the raw external interrupt.
// Registers are reached through a single-beat MMIO port; every request gets
// a response exactly one cycle later.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_req_valid         request strobe (one cycle per request)
//   i_req_we            1 = write, 0 = read
//   i_req_addr          byte address inside the 32-byte window ([1:0] ignored)
//   i_req_wdata         write data
//   i_req_wstrb         per-byte write enables
//   o_rsp_valid         response strobe, one cycle after each request
//   o_rsp_rdata         read data (0 for writes and when no response)
//   i_ext_irq           asynchronous level external interrupt
//   o_interrupts        pending bits {meip, mtip, msip} (bit 2 .. bit 0)
//   o_mtime             live mtime value
//
// Register map (byte offsets):
//   0x00 msip (bit 0), 0x08/0x0C mtimecmp lo/hi, 0x10/0x14 mtime lo/hi.
//   Anything else reads 0, ignores writes and still responds.
module clint_timer #(
    parameter int ADDR_W      = 5,
    parameter int TICK_DIV    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    input  logic              i_req_we,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    input  logic [3:0]        i_req_wstrb,
    output logic              o_rsp_valid,
    output logic [31:0]       o_rsp_rdata,
    input  logic              i_ext_irq,
    output logic [2:0]        o_interrupts,
    output logic [63:0]       o_mtime
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

    localparam logic [ADDR_W-3:0] OFF_MSIP     = (ADDR_W-2)'(0);
    localparam logic [ADDR_W-3:0] OFF_CMP_LO   = (ADDR_W-2)'(2);
    localparam logic [ADDR_W-3:0] OFF_CMP_HI   = (ADDR_W-2)'(3);
    localparam logic [ADDR_W-3:0] OFF_MTIME_LO = (ADDR_W-2)'(4);
    localparam logic [ADDR_W-3:0] OFF_MTIME_HI = (ADDR_W-2)'(5);

    logic [63:0]            mtime;
    logic [63:0]            mtimecmp;
    logic                   msip;
    logic                   mtip;
    logic [PRESC_W-1:0]     prescaler;
    logic [31:0]            mtime_hi_shadow;
    logic                   last_was_lo_read;
    logic [SYNC_STAGES-1:0] irq_sync;
    logic                   rsp_valid;
    logic [31:0]            rsp_rdata;

    logic [ADDR_W-3:0]      word;
    logic                   wr;
    logic                   rd;
    logic                   mtime_wr_lo;
    logic                   mtime_wr_hi;
    logic [31:0]            read_data;
    logic                   unused_addr_bits;

    assign word             = i_req_addr[ADDR_W-1:2];
    assign unused_addr_bits = &{1'b0, i_req_addr[1:0]};
    assign wr               = i_req_valid & i_req_we;
    assign rd               = i_req_valid & ~i_req_we;

    // A write with no byte enables is a pure no-op, so it must not disturb
    // the timebase either.
    assign mtime_wr_lo = wr && (word == OFF_MTIME_LO) && (i_req_wstrb != 4'b0000);
    assign mtime_wr_hi = wr && (word == OFF_MTIME_HI) && (i_req_wstrb != 4'b0000);

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] result;
        result = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                result[b*8 +: 8] = new_word[b*8 +: 8];
            end
        end
        return result;
    endfunction

    // Read mux; a hi read right after a lo read returns the captured upper
    // half so software sees a consistent 64-bit snapshot across a carry.
    always_comb begin
        read_data = 32'd0;
        case (word)
            OFF_MSIP:     read_data = {31'd0, msip};
            OFF_CMP_LO:   read_data = mtimecmp[31:0];
            OFF_CMP_HI:   read_data = mtimecmp[63:32];
            OFF_MTIME_LO: read_data = mtime[31:0];
            OFF_MTIME_HI: read_data = last_was_lo_read ? mtime_hi_shadow : mtime[63:32];
            default:      read_data = 32'd0;
        endcase
    end

    // Timebase: a software write to either mtime half wins over the tick,
    // keeps unwritten bytes at their pre-increment value and restarts the
    // prescaler so the next tick comes a full TICK_DIV cycles later.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mtime     <= 64'd0;
            prescaler <= '0;
        end else if (mtime_wr_lo || mtime_wr_hi) begin
            mtime[31:0]  <= mtime_wr_lo ? merge_bytes(mtime[31:0],  i_req_wdata, i_req_wstrb)
                                        : mtime[31:0];
            mtime[63:32] <= mtime_wr_hi ? merge_bytes(mtime[63:32], i_req_wdata, i_req_wstrb)
                                        : mtime[63:32];
            prescaler    <= '0;
        end else if (prescaler == PRESC_MAX) begin
            mtime     <= mtime + 64'd1;
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PRESC_W'(1);
        end
    end

    // Compare and software-interrupt registers. mtip samples the values in
    // place before this edge, so a same-cycle mtimecmp write only counts
    // from the following cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip     <= 1'b0;
            mtip     <= 1'b0;
        end else begin
            mtip <= (mtime >= mtimecmp);
            if (wr && (word == OFF_CMP_LO)) begin
                mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], i_req_wdata, i_req_wstrb);
            end
            if (wr && (word == OFF_CMP_HI)) begin
                mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], i_req_wdata, i_req_wstrb);
            end
            if (wr && (word == OFF_MSIP) && i_req_wstrb[0]) begin
                msip <= i_req_wdata[0];
            end
        end
    end

    // Response path and the lo/hi snapshot tracking. The "previous request"
    // flag only moves on requests, so idle gaps do not break a lo/hi pair.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rsp_valid        <= 1'b0;
            rsp_rdata        <= 32'd0;
            mtime_hi_shadow  <= 32'd0;
            last_was_lo_read <= 1'b0;
        end else begin
            rsp_valid <= i_req_valid;
            rsp_rdata <= rd ? read_data : 32'd0;
            if (rd && (word == OFF_MTIME_LO)) begin
                mtime_hi_shadow <= mtime[63:32];
            end
            if (i_req_valid) begin
                last_was_lo_read <= rd && (word == OFF_MTIME_LO);
            end
        end
    end

    // External interrupt synchroniser, level only.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            irq_sync <= '0;
        end else begin
            irq_sync <= {irq_sync[SYNC_STAGES-2:0], i_ext_irq};
        end
    end

    assign o_rsp_valid  = rsp_valid;
    assign o_rsp_rdata  = rsp_rdata;
    assign o_interrupts = {irq_sync[SYNC_STAGES-1], mtip, msip};
    assign o_mtime      = mtime;

endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: self-checking bench for clint_timer.
//
// Two instances share every input: one with TICK_DIV=1 and one with
// TICK_DIV=4. A behavioural model per instance predicts the visible
// outputs each cycle; directed steps add fixed expected values on top.
module tb_clint_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [4:0]  req_addr = 5'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_wstrb = 4'd0;
    logic        ext_irq = 1'b0;

    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic [2:0]  irqs      [2];
    logic [63:0] mtime     [2];

    int tests    = 0;
    int failures = 0;

    clint_timer #(.ADDR_W(5), .TICK_DIV(1), .SYNC_STAGES(2)) u_dut1 (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .i_req_we(req_we), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
        .o_rsp_valid(rsp_valid[0]), .o_rsp_rdata(rsp_rdata[0]),
        .i_ext_irq(ext_irq), .o_interrupts(irqs[0]), .o_mtime(mtime[0])
    );

    clint_timer #(.ADDR_W(5), .TICK_DIV(4), .SYNC_STAGES(2)) u_dut4 (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .i_req_we(req_we), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
        .o_rsp_valid(rsp_valid[1]), .o_rsp_rdata(rsp_rdata[1]),
        .i_ext_irq(ext_irq), .o_interrupts(irqs[1]), .o_mtime(mtime[1])
    );

    always #5 clk = ~clk;

    // Reference state, one entry per instance.
    logic [63:0] mMtime   [2];
    logic [63:0] mCmp     [2];
    bit          mMsip    [2];
    bit          mMtip    [2];
    int          mCycles  [2];
    logic [31:0] mShadow  [2];
    bit          mLastLo  [2];
    bit          mIrqOld  [2];
    bit          mIrqOlder[2];
    bit          mRspValid[2];
    logic [31:0] mRspData [2];

    function automatic logic [31:0] byteMerge(input logic [31:0] oldWord,
                                              input logic [31:0] newWord,
                                              input logic [3:0]  strb);
        logic [31:0] r;
        r = oldWord;
        for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = newWord[b*8 +: 8];
        return r;
    endfunction

    // Advance the model of instance k across one clock edge, using the
    // inputs currently driven.
    function automatic void modelStep(input int k);
        int          div;
        int          offset;
        logic [63:0] oldTime;
        logic [63:0] oldCmp;
        bit          isWr;
        bit          isRd;
        div = (k == 0) ? 1 : 4;
        if (rst) begin
            mMtime[k] = 64'd0; mCmp[k] = '1; mMsip[k] = 0; mMtip[k] = 0;
            mCycles[k] = 0; mShadow[k] = 32'd0; mLastLo[k] = 0;
            mIrqOld[k] = 0; mIrqOlder[k] = 0; mRspValid[k] = 0; mRspData[k] = 32'd0;
            return;
        end
        offset  = int'(req_addr) & 32'h1C;
        oldTime = mMtime[k];
        oldCmp  = mCmp[k];
        isWr    = req_valid && req_we;
        isRd    = req_valid && !req_we;

        mRspValid[k] = req_valid;
        mRspData[k]  = 32'd0;
        if (isRd) begin
            case (offset)
                'h00: mRspData[k] = {31'd0, mMsip[k]};
                'h08: mRspData[k] = oldCmp[31:0];
                'h0C: mRspData[k] = oldCmp[63:32];
                'h10: mRspData[k] = oldTime[31:0];
                'h14: mRspData[k] = mLastLo[k] ? mShadow[k] : oldTime[63:32];
                default: mRspData[k] = 32'd0;
            endcase
        end
        if (isRd && offset == 'h10) mShadow[k] = oldTime[63:32];
        if (req_valid) mLastLo[k] = isRd && (offset == 'h10);

        mMtip[k] = (oldTime >= oldCmp);

        if (isWr && (offset == 'h10 || offset == 'h14) && req_wstrb != 4'd0) begin
            if (offset == 'h10) mMtime[k][31:0]  = byteMerge(oldTime[31:0],  req_wdata, req_wstrb);
            else                mMtime[k][63:32] = byteMerge(oldTime[63:32], req_wdata, req_wstrb);
            mCycles[k] = 0;
        end else begin
            mCycles[k] = mCycles[k] + 1;
            if (mCycles[k] == div) begin
                mMtime[k]  = oldTime + 64'd1;
                mCycles[k] = 0;
            end
        end

        if (isWr && offset == 'h08) mCmp[k][31:0]  = byteMerge(oldCmp[31:0],  req_wdata, req_wstrb);
        if (isWr && offset == 'h0C) mCmp[k][63:32] = byteMerge(oldCmp[63:32], req_wdata, req_wstrb);
        if (isWr && offset == 'h00 && req_wstrb[0]) mMsip[k] = req_wdata[0];

        mIrqOlder[k] = mIrqOld[k];
        mIrqOld[k]   = ext_irq;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        tests++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkModels();
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("mtime_div%0d", k), mtime[k], mMtime[k]);
            checkOutput($sformatf("irqs_div%0d", k), 64'(irqs[k]),
                        64'({mIrqOlder[k], mMtip[k], mMsip[k]}));
            checkOutput($sformatf("rsp_valid_div%0d", k), 64'(rsp_valid[k]), 64'(mRspValid[k]));
            checkOutput($sformatf("rsp_rdata_div%0d", k), 64'(rsp_rdata[k]), 64'(mRspData[k]));
        end
    endtask

    // Drive one cycle of inputs, update the models, cross the edge and compare.
    task automatic applyStimulus(input bit v, input bit we, input logic [4:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wstrb);
        req_valid = v;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = wstrb;
        modelStep(0);
        modelStep(1);
        @(posedge clk);
        #1;
        checkModels();
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 4'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [63:0] prev;
        int          n;
        bit          found;
        bit          v;
        bit          we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;

        // Reset and free-running count.
        rst = 1'b1;
        idle();
        idle();
        checkOutput("rst_mtime", mtime[0], 64'd0);
        checkOutput("rst_irqs", 64'(irqs[0]), 64'd0);
        checkOutput("rst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) idle();
        checkOutput("idle10_mtime", mtime[0], 64'd10);
        checkOutput("idle10_irqs", 64'(irqs[0]), 64'd0);
        applyStimulus(1, 0, 5'h08, 32'd0, 4'd0);
        checkOutput("cmp_lo_reset", 64'(rsp_rdata[0]), 64'hFFFF_FFFF);
        checkOutput("cmp_lo_valid", 64'(rsp_valid[0]), 64'd1);
        applyStimulus(1, 0, 5'h0C, 32'd0, 4'd0);
        checkOutput("cmp_hi_reset", 64'(rsp_rdata[0]), 64'hFFFF_FFFF);

        // Timer interrupt rise and clear.
        applyStimulus(1, 1, 5'h0C, 32'd0, 4'hF);
        applyStimulus(1, 1, 5'h08, 32'd20, 4'hF);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            idle();
            if (mtime[0] == 64'd20) begin
                checkOutput("mtip_at_20", 64'(irqs[0][1]), 64'd0);
                idle();
                checkOutput("mtip_rise", 64'(irqs[0][1]), 64'd1);
                found = 1;
            end
        end
        if (!found) checkOutput("mtip_timeout", 64'd0, 64'd1);
        applyStimulus(1, 1, 5'h0C, 32'd1, 4'hF);
        checkOutput("mtip_hold_on_write", 64'(irqs[0][1]), 64'd1);
        idle();
        checkOutput("mtip_clear", 64'(irqs[0][1]), 64'd0);

        // Software interrupt.
        applyStimulus(1, 1, 5'h00, 32'd1, 4'b0001);
        checkOutput("msip_set", 64'(irqs[0][0]), 64'd1);
        applyStimulus(1, 1, 5'h00, 32'd0, 4'b0001);
        checkOutput("msip_clear", 64'(irqs[0][0]), 64'd0);
        applyStimulus(1, 1, 5'h00, 32'd1, 4'b0000);
        checkOutput("msip_nostrb", 64'(irqs[0][0]), 64'd0);
        checkOutput("nostrb_rsp_valid", 64'(rsp_valid[0]), 64'd1);
        checkOutput("nostrb_rsp_rdata", 64'(rsp_rdata[0]), 64'd0);

        // Atomic lo/hi read across a carry.
        applyStimulus(1, 1, 5'h14, 32'd0, 4'hF);
        applyStimulus(1, 1, 5'h10, 32'hFFFF_FFFE, 4'hF);
        idle();
        applyStimulus(1, 0, 5'h10, 32'd0, 4'd0);
        checkOutput("snap_lo", 64'(rsp_rdata[0]), 64'hFFFF_FFFF);
        applyStimulus(1, 0, 5'h14, 32'd0, 4'd0);
        checkOutput("snap_hi_shadow", 64'(rsp_rdata[0]), 64'd0);
        idle();
        applyStimulus(1, 0, 5'h14, 32'd0, 4'd0);
        checkOutput("live_hi", 64'(rsp_rdata[0]), 64'd1);

        // Prescaled instance: period and restart after an mtime write.
        prev = mtime[1];
        for (int i = 0; i < 20 && mtime[1] == prev; i++) idle();
        prev = mtime[1];
        n = 0;
        for (int i = 0; i < 20 && mtime[1] == prev; i++) begin
            idle();
            n++;
        end
        checkOutput("div4_period", 64'(n), 64'd4);
        idle();
        applyStimulus(1, 1, 5'h10, 32'd100, 4'hF);
        checkOutput("div4_write", mtime[1][31:0], 64'd100);
        n = 0;
        for (int i = 0; i < 20 && mtime[1][31:0] == 32'd100; i++) begin
            idle();
            n++;
        end
        checkOutput("div4_after_write", 64'(n), 64'd4);

        // External interrupt synchroniser.
        ext_irq = 1'b1;
        idle();
        checkOutput("meip_pulse_d1", 64'(irqs[0][2]), 64'd0);
        ext_irq = 1'b0;
        idle();
        checkOutput("meip_pulse_d2", 64'(irqs[0][2]), 64'd1);
        idle();
        checkOutput("meip_pulse_end", 64'(irqs[0][2]), 64'd0);
        ext_irq = 1'b1;
        idle();
        checkOutput("meip_hold_d1", 64'(irqs[0][2]), 64'd0);
        idle();
        checkOutput("meip_hold_d2", 64'(irqs[0][2]), 64'd1);
        idle();
        checkOutput("meip_hold_d3", 64'(irqs[0][2]), 64'd1);

        // Unmapped offset.
        applyStimulus(1, 0, 5'h1C, 32'd0, 4'd0);
        checkOutput("unmapped_valid", 64'(rsp_valid[0]), 64'd1);
        checkOutput("unmapped_rdata", 64'(rsp_rdata[0]), 64'd0);

        // Reset in the middle of activity, with a request that must be dropped.
        applyStimulus(1, 1, 5'h00, 32'd1, 4'b0001);
        rst = 1'b1;
        applyStimulus(1, 0, 5'h10, 32'd0, 4'd0);
        checkOutput("midrst_mtime", mtime[0], 64'd0);
        checkOutput("midrst_irqs", 64'(irqs[0]), 64'd0);
        checkOutput("midrst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
        checkOutput("midrst_rsp_rdata", 64'(rsp_rdata[0]), 64'd0);
        rst = 1'b0;
        ext_irq = 1'b0;
        applyStimulus(1, 0, 5'h08, 32'd0, 4'd0);
        checkOutput("midrst_cmp_lo", 64'(rsp_rdata[0]), 64'hFFFF_FFFF);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            v     = ($urandom % 3) != 0;
            we    = $urandom % 2;
            addr  = 5'(($urandom % 8) * 4 + ($urandom % 4));
            wstrb = 4'($urandom);
            case (addr & 5'h1C)
                5'h08:   wdata = $urandom_range(0, 800);
                5'h10:   wdata = $urandom_range(0, 600);
                5'h0C, 5'h14: wdata = $urandom_range(0, 1);
                default: wdata = $urandom;
            endcase
            if ((addr & 5'h1C) == 5'h10 || (addr & 5'h1C) == 5'h14) begin
                if (wstrb == 4'd0) wstrb = 4'hF;
            end
            if (($urandom % 4) == 0) ext_irq = ~ext_irq;
            rst = ($urandom % 100) == 0;
            applyStimulus(v, we, addr, wdata, wstrb);
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
